halt_bcast_r: RTL

- Pipelined halt/release broadcaster for a wide lane bundle.
- Accepts one halt or release command, fans the level out to WIDTH lanes through a registered tree with bounded fanout, then collects per-lane acknowledges through a pipelined AND reduction.
- Reports completion or timeout.
- It is the command side that drives the per-lane halt logic whose status is collected by the pipelined OR reduction trees in the SL3 user-control halt/FEC path.

---
 rtl/halt_bcast_pkg.sv | 52 +++++
 rtl/halt_bcast_r_and.sv | 50 +++++
 rtl/halt_bcast_r_fanout.sv | 49 ++++
 rtl/halt_bcast_r.sv | 132 +++++++++++++
 4 files changed

// File: rtl/halt_bcast_pkg.sv
// ============================================================================
// Module      : halt_bcast_pkg
// Description : Shared FSM state type and tree-sizing helpers for halt_bcast_r.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package halt_bcast_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Node count of a tree level 'depth' reductions away from the lane level.
    function automatic int level_width(input int width, input int fanout, input int depth);
        int w = width;
        for (int i = 0; i < depth; i++) w = ceil_div(w, fanout);
        return w;
    endfunction

    function automatic int tree_stages(input int width, input int fanout);
        int s = 0;
        int w = width;
        for (int i = 0; i < 32; i++) begin
            if (w > 1) begin
                w = ceil_div(w, fanout);
                s++;
            end
        end
        return (s < 1) ? 1 : s;
    endfunction

    // Sum of level widths for depths d_lo..d_hi inclusive (0 when empty).
    function automatic int width_sum(input int width, input int fanout, input int d_lo, input int d_hi);
        int acc = 0;
        for (int d = d_lo; d <= d_hi; d++) acc += level_width(width, fanout, d);
        return acc;
    endfunction

    function automatic int settle_cycles(input int fo_stages, input int and_stages);
        return fo_stages + and_stages + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/halt_bcast_r_and.sv
// ============================================================================
// Module      : and_r
// Description : Pipelined AND reduction, <= FANOUT inputs per node, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_r
    import halt_bcast_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int FANOUT = 6
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    localparam int STAGES = tree_stages(WIDTH, FANOUT);
    localparam int TOTAL  = width_sum(WIDTH, FANOUT, 1, STAGES);

    logic [TOTAL-1:0] r_red;
    logic [TOTAL-1:0] w_next;

    // A short last group simply ANDs fewer inputs, which equals padding with 1.
    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int N_IN = level_width(WIDTH, FANOUT, s - 1);
        localparam int N    = level_width(WIDTH, FANOUT, s);
        localparam int OFF  = width_sum(WIDTH, FANOUT, 1, s - 1);
        for (genvar j = 0; j < N; j++) begin : g_node
            localparam int LO = j * FANOUT;
            localparam int HI = (LO + FANOUT < N_IN) ? (LO + FANOUT - 1) : (N_IN - 1);
            if (s == 1) begin : g_first
                assign w_next[OFF + j] = &din[HI:LO];
            end else begin : g_inner
                localparam int POFF = width_sum(WIDTH, FANOUT, 1, s - 2);
                assign w_next[OFF + j] = &r_red[POFF + HI : POFF + LO];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_red <= w_next;
    end

    assign dout = r_red[TOTAL-1];

endmodule

`default_nettype wire

// File: rtl/halt_bcast_r_fanout.sv
// ============================================================================
// Module      : fanout_r
// Description : Registered broadcast tree; every register drives <= FANOUT loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fanout_r
    import halt_bcast_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int FANOUT = 6
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             din,
    output logic [WIDTH-1:0] dout
);

    localparam int STAGES = tree_stages(WIDTH, FANOUT);
    localparam int TOTAL  = width_sum(WIDTH, FANOUT, 0, STAGES - 1);

    // All stages packed into one vector; stage s sits at depth STAGES-s.
    logic [TOTAL-1:0] r_tree;
    logic [TOTAL-1:0] w_next;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
        localparam int N   = level_width(WIDTH, FANOUT, STAGES - s);
        localparam int OFF = width_sum(WIDTH, FANOUT, STAGES - s + 1, STAGES - 1);
        for (genvar j = 0; j < N; j++) begin : g_node
            if (s == 1) begin : g_root
                assign w_next[OFF + j] = din;
            end else begin : g_inner
                localparam int POFF = width_sum(WIDTH, FANOUT, STAGES - s + 2, STAGES - 1);
                assign w_next[OFF + j] = r_tree[POFF + j / FANOUT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) r_tree <= '0;
        else      r_tree <= w_next;
    end

    assign dout = r_tree[TOTAL-1 -: WIDTH];

endmodule

`default_nettype wire

// File: rtl/halt_bcast_r.sv
// ============================================================================
// Module      : halt_bcast_r
// Description : Halt/release broadcaster with pipelined fan-out, ack AND
//               reduction, settle masking and optional timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halt_bcast_r
    import halt_bcast_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int FANOUT    = 6,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_halt,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic [WIDTH-1:0]     lane_halt,
    input  logic [WIDTH-1:0]     lane_ack,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out
);

    localparam int FO_STAGES  = tree_stages(WIDTH, FANOUT);
    localparam int AND_STAGES = tree_stages(WIDTH, FANOUT);
    localparam int SETTLE_CYC = settle_cycles(FO_STAGES, AND_STAGES);
    localparam int SC_W       = $clog2(SETTLE_CYC);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

    state_t                r_state;
    logic                  r_target;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic [TIMEOUT_W-1:0]  r_tmo_cnt;
    logic [SC_W-1:0]       r_settle_cnt;
    logic                  r_done;
    logic                  r_timed_out;

    logic [WIDTH-1:0]      w_lane_halt;
    logic [WIDTH-1:0]      w_match;
    logic                  w_all_match;
    logic [TIMEOUT_W-1:0]  w_tmo_next;
    logic                  w_tmo_hit;

    fanout_r #(
        .WIDTH  (WIDTH),
        .FANOUT (FANOUT)
    ) u_fanout (
        .clk  (clk),
        .sclr (sclr),
        .din  (r_target),
        .dout (w_lane_halt)
    );

    // Each lane copy of the target equals r_target once the fan-out has settled,
    // so comparing against it keeps the target register's load count bounded.
    assign w_match = ~(lane_ack ^ w_lane_halt);

    and_r #(
        .WIDTH  (WIDTH),
        .FANOUT (FANOUT)
    ) u_and (
        .clk  (clk),
        .din  (w_match),
        .dout (w_all_match)
    );

    assign w_tmo_next = (&r_tmo_cnt) ? r_tmo_cnt : (r_tmo_cnt + TIMEOUT_W'(1));
    assign w_tmo_hit  = (r_tmo != '0) && (w_tmo_next == r_tmo);

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state      <= IDLE;
            r_target     <= 1'b0;
            r_tmo        <= '0;
            r_tmo_cnt    <= '0;
            r_settle_cnt <= '0;
            r_done       <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_target     <= req_halt;
                        r_tmo        <= timeout_cycles;
                        r_tmo_cnt    <= '0;
                        r_settle_cnt <= '0;
                        r_state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    r_tmo_cnt <= w_tmo_next;
                    if (w_tmo_hit) begin
                        r_timed_out <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= WAIT;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SC_W'(1);
                    end
                end
                WAIT: begin
                    r_tmo_cnt <= w_tmo_next;
                    // Match takes priority over a timeout expiring on the same edge.
                    if (w_all_match) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_tmo_hit) begin
                        r_timed_out <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE) && !sclr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign timed_out = r_timed_out;
    assign lane_halt = w_lane_halt;

endmodule

`default_nettype wire
